// File: rtl/seq_mult_dot_acc.sv
// seq_mult_dot_acc: hands operand pairs one at a time to a 6x6 sequential multiplier
// and accumulates the products into a dot-product sum, with wrap and timeout flags.
module seq_mult_dot_acc #(
   parameter int OP_W    = 6,
   parameter int ACC_W   = 20,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   input  logic              in_last,
   output logic [OP_W-1:0]   mult_a,
   output logic [OP_W-1:0]   mult_b,
   output logic              mult_start,
   input  logic              mult_load,
   input  logic [2*OP_W-1:0] mult_product,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf,
   output logic              out_err,
   output logic              busy
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE     = 3'd1;
   localparam logic [2:0] WAIT_BUSY = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] ACCUM     = 3'd4;
   localparam logic [2:0] OUT       = 3'd5;

   localparam int              WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   logic [2:0]        state_reg, state_next;
   logic [WAIT_W-1:0] wait_reg;
   logic [ACC_W-1:0]  acc_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              ovf_reg;
   logic              err_reg;
   logic [2*OP_W-1:0] prod_reg;
   logic              last_reg;
   logic [OP_W-1:0]   mult_a_reg, mult_b_reg;
   logic              in_ready_reg, out_valid_reg, busy_reg;
   logic [ACC_W:0]    acc_sum;
   logic              timed_out;

   assign timed_out = (wait_reg == WAIT_LAST);
   assign acc_sum   = {1'b0, acc_reg} + {{(ACC_W + 1 - 2*OP_W){1'b0}}, prod_reg};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (in_valid && in_ready_reg) state_next = ISSUE;
         // A multiplier left busy by an earlier abort or reset is allowed to finish first.
         ISSUE:     if (mult_load) state_next = WAIT_BUSY;
         WAIT_BUSY: begin
            if (!mult_load)     state_next = WAIT_DONE;
            else if (timed_out) state_next = OUT;
         end
         WAIT_DONE: begin
            if (mult_load)      state_next = ACCUM;
            else if (timed_out) state_next = OUT;
         end
         ACCUM:     state_next = last_reg ? OUT : IDLE;
         OUT:       if (out_valid_reg && out_ready) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= IDLE;
         wait_reg      <= '0;
         acc_reg       <= '0;
         count_reg     <= '0;
         ovf_reg       <= 1'b0;
         err_reg       <= 1'b0;
         prod_reg      <= '0;
         last_reg      <= 1'b0;
         mult_a_reg    <= '0;
         mult_b_reg    <= '0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         in_ready_reg  <= (state_next == IDLE);
         out_valid_reg <= (state_next == OUT);
         busy_reg      <= (state_next != IDLE);

         if (state_next != state_reg)
            wait_reg <= '0;
         else if (state_reg == WAIT_BUSY || state_reg == WAIT_DONE)
            wait_reg <= wait_reg + 1'b1;

         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready_reg) begin
                  mult_a_reg <= in_a;
                  mult_b_reg <= in_b;
                  last_reg   <= in_last;
               end
            end
            WAIT_BUSY: begin
               if (state_next == OUT) err_reg <= 1'b1;
            end
            WAIT_DONE: begin
               if (mult_load)               prod_reg <= mult_product;
               else if (state_next == OUT)  err_reg  <= 1'b1;
            end
            ACCUM: begin
               acc_reg <= acc_sum[ACC_W-1:0];
               if (acc_sum[ACC_W]) ovf_reg <= 1'b1;
               if (count_reg != {CNT_W{1'b1}}) count_reg <= count_reg + 1'b1;
            end
            OUT: begin
               if (out_valid_reg && out_ready) begin
                  acc_reg   <= '0;
                  count_reg <= '0;
                  ovf_reg   <= 1'b0;
                  err_reg   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready   = in_ready_reg;
   assign mult_a     = mult_a_reg;
   assign mult_b     = mult_b_reg;
   assign mult_start = (state_reg == ISSUE) && mult_load;
   assign out_valid  = out_valid_reg;
   assign out_sum    = acc_reg;
   assign out_count  = count_reg;
   assign out_ovf    = ovf_reg;
   assign out_err    = err_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_seq_mult_dot_acc.sv
// Bench for seq_mult_dot_acc: two instances (ACC_W=20 and ACC_W=12) share stimulus,
// each with a behavioural multiplier that holds load low for 7 cycles after a start.
module tb_seq_mult_dot_acc;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [5:0]  in_a, in_b;
   logic        in_last;
   logic        out_ready;
   logic        stub;

   logic [1:0]  in_ready_s, mult_start_s, mult_load_s, out_valid_s, out_ovf_s, out_err_s, busy_s;
   logic [5:0]  mult_a_s [2];
   logic [5:0]  mult_b_s [2];
   logic [11:0] prod_s [2];
   logic [7:0]  out_count_s [2];
   logic [19:0] out_sum0;
   logic [11:0] out_sum1;

   seq_mult_dot_acc #(.OP_W(6), .ACC_W(20), .CNT_W(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready_s[0]),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mult_a(mult_a_s[0]), .mult_b(mult_b_s[0]), .mult_start(mult_start_s[0]),
      .mult_load(mult_load_s[0]), .mult_product(prod_s[0]),
      .out_valid(out_valid_s[0]), .out_ready(out_ready),
      .out_sum(out_sum0), .out_count(out_count_s[0]),
      .out_ovf(out_ovf_s[0]), .out_err(out_err_s[0]), .busy(busy_s[0])
   );

   seq_mult_dot_acc #(.OP_W(6), .ACC_W(12), .CNT_W(8), .TIMEOUT(15)) dut12 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready_s[1]),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mult_a(mult_a_s[1]), .mult_b(mult_b_s[1]), .mult_start(mult_start_s[1]),
      .mult_load(mult_load_s[1]), .mult_product(prod_s[1]),
      .out_valid(out_valid_s[1]), .out_ready(out_ready),
      .out_sum(out_sum1), .out_count(out_count_s[1]),
      .out_ovf(out_ovf_s[1]), .out_err(out_err_s[1]), .busy(busy_s[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural multiplier: start sampled, then load low for 7 cycles, product valid when load returns
   logic [3:0] mcnt [2];
   logic [1:0] pend;
   logic [5:0] opa [2];
   logic [5:0] opb [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 4'd0;
         opa[k] = 6'd0;
         opb[k] = 6'd0;
         prod_s[k] = 12'd0;
      end
      pend = 2'b00;
   end

   assign mult_load_s[0] = (mcnt[0] == 4'd0);
   assign mult_load_s[1] = (mcnt[1] == 4'd0);

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (stub) begin
            mcnt[k] <= 4'd0;
            pend[k] <= 1'b0;
         end else if (mult_start_s[k]) begin
            pend[k] <= 1'b1;
            opa[k]  <= mult_a_s[k];
            opb[k]  <= mult_b_s[k];
         end else if (pend[k]) begin
            pend[k]   <= 1'b0;
            mcnt[k]   <= 4'd7;
            prod_s[k] <= 12'hABC;
         end else if (mcnt[k] == 4'd1) begin
            mcnt[k]   <= 4'd0;
            prod_s[k] <= {6'd0, opa[k]} * {6'd0, opb[k]};
         end else if (mcnt[k] != 4'd0) begin
            mcnt[k] <= mcnt[k] - 4'd1;
         end
      end
   end

   typedef struct {
      logic [19:0] sum;
      logic [7:0]  count;
      logic        ovf;
      logic        err;
      logic [11:0] sum12;
      logic        ovf12;
   } exp_t;

   typedef struct {
      int     a;
      int     b;
      bit     last;
      longint total;
      int     count;
   } vec_t;

   exp_t sb_q [$];
   vec_t vecs [10];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_res = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push_exp(input longint total, input int cnt, input bit err);
      exp_t e;
      e.sum   = 20'(total);
      e.count = 8'(cnt);
      e.ovf   = (total >= 64'd1048576);
      e.err   = err;
      e.sum12 = 12'(total);
      e.ovf12 = (total >= 64'd4096);
      sb_q.push_back(e);
   endtask

   // scoreboard: pop on each result handshake
   always @(negedge clk) begin
      if (rst && out_valid_s[0] && out_ready) begin
         n_res++;
         $display("result %0d: sum=%0d count=%0d ovf=%0d err=%0d sum12=%0d ovf12=%0d",
                  n_res, out_sum0, out_count_s[0], out_ovf_s[0], out_err_s[0], out_sum1, out_ovf_s[1]);
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got sum %0d expected no result", out_sum0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("out_sum",   out_sum0,       e.sum);
            chk("out_count", out_count_s[0], e.count);
            chk("out_ovf",   out_ovf_s[0],   e.ovf);
            chk("out_err",   out_err_s[0],   e.err);
            chk("valid12",   out_valid_s[1], 1);
            chk("sum12",     out_sum1,       e.sum12);
            chk("ovf12",     out_ovf_s[1],   e.ovf12);
         end
      end
   end

   task automatic send_pair(input logic [5:0] a, input logic [5:0] b, input bit last);
      int g;
      in_a = a;
      in_b = b;
      in_last = last;
      in_valid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!in_ready_s[0] && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready_s[0]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      $display("pair a=%0d b=%0d last=%0d accepted", a, b, last);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb_q.size() != 0 && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d results pending expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic wait_out_valid(output int n);
      n = 0;
      while (!out_valid_s[0] && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_last = 1'b0;
      out_ready = 1'b1;
      stub = 1'b0;

      vecs = '{
         '{3, 5, 0, 0, 0},      '{7, 9, 0, 0, 0},      '{63, 63, 1, 4047, 3},
         '{0, 63, 1, 0, 1},     '{63, 63, 0, 0, 0},    '{63, 63, 1, 7938, 2},
         '{1, 1, 1, 1, 1},      '{10, 20, 0, 0, 0},    '{5, 5, 0, 0, 0},
         '{2, 3, 1, 231, 3}
      };

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",   in_ready_s[0],   0);
      chk("rst_busy",       busy_s[0],       0);
      chk("rst_out_valid",  out_valid_s[0],  0);
      chk("rst_mult_start", mult_start_s[0], 0);
      chk("rst_out_sum",    out_sum0,        0);
      chk("rst_out_count",  out_count_s[0],  0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_in_ready", in_ready_s[0], 1);

      // table-driven dot products
      for (int i = 0; i < 10; i++) begin
         send_pair(6'(vecs[i].a), 6'(vecs[i].b), vecs[i].last);
         if (vecs[i].last) push_exp(vecs[i].total, vecs[i].count, 1'b0);
      end
      drain();

      // latency of a single last pair
      send_pair(6'd0, 6'd63, 1'b1);
      push_exp(0, 1, 1'b0);
      wait_out_valid(n);
      chk("latency", n, 11);
      drain();

      // back-pressure in OUT with a new pair already waiting
      out_ready = 1'b0;
      send_pair(6'd2, 6'd3, 1'b0);
      send_pair(6'd4, 6'd5, 1'b1);
      push_exp(26, 2, 1'b0);
      wait_out_valid(n);
      in_a = 6'd1;
      in_b = 6'd2;
      in_last = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid",    out_valid_s[0], 1);
         chk("hold_sum",      out_sum0,       26);
         chk("hold_in_ready", in_ready_s[0],  0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_hs_valid",    out_valid_s[0], 0);
      chk("post_hs_sum",      out_sum0,       0);
      chk("post_hs_count",    out_count_s[0], 0);
      chk("post_hs_busy",     busy_s[0],      0);
      chk("post_hs_in_ready", in_ready_s[0],  1);
      push_exp(2, 1, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("late_accept_busy", busy_s[0], 1);
      drain();

      // 265 full-scale terms: 20-bit wrap and count saturation
      for (int i = 0; i < 265; i++) send_pair(6'd63, 6'd63, i == 264);
      push_exp(64'd1051785, 255, 1'b0);
      drain();

      // reset while the multiplier is busy
      send_pair(6'd3, 6'd5, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy_s[0], 1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_in_ready",   in_ready_s[0],   0);
      chk("mid_rst_busy",       busy_s[0],       0);
      chk("mid_rst_out_valid",  out_valid_s[0],  0);
      chk("mid_rst_mult_start", mult_start_s[0], 0);
      chk("mid_rst_mult_a",     mult_a_s[0],     0);
      chk("mid_rst_mult_b",     mult_b_s[0],     0);
      chk("mid_rst_out_sum",    out_sum0,        0);
      chk("mid_rst_out_err",    out_err_s[0],    0);
      rst = 1'b1;
      send_pair(6'd7, 6'd9, 1'b1);
      push_exp(63, 1, 1'b0);
      chk("issue_wait_load",  mult_load_s[0],  0);
      chk("issue_wait_start", mult_start_s[0], 0);
      drain();

      // multiplier that never goes busy: timeout abort
      stub = 1'b1;
      send_pair(6'd5, 6'd5, 1'b1);
      push_exp(0, 0, 1'b1);
      wait_out_valid(n);
      chk("timeout_reached", (n >= 15 && n <= 18) ? 1 : 0, 1);
      drain();
      @(posedge clk);
      #1;
      chk("err_cleared",        out_err_s[0],   0);
      chk("err_cleared_valid",  out_valid_s[0], 0);
      stub = 1'b0;

      // normal operation resumes after the abort
      send_pair(6'd6, 6'd7, 1'b0);
      send_pair(6'd8, 6'd9, 1'b1);
      push_exp(114, 2, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
